// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: each channel strobes tick for one clk every Peff counting cycles.
// Tick is registered (first tick on the Peff-th counting edge); no backpressure, pause/en simply freeze counting.
module tick_gen_multi #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 100000000,
    parameter int CH_W           = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic [NUM_CH-1:0] restart,
    input  logic              pause,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active
);

    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  last_cnt [NUM_CH];
    logic [NUM_CH-1:0] armed_q, armed_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    // Terminal count is Peff-1, with a zero period treated as one.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            last_cnt[i] = (period_q[i] == '0) ? '0 : period_q[i] - CNT_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            armed_d[i]  = armed_q[i];
            tick_d[i]   = 1'b0;

            // Out-of-range channel indices match no channel and are dropped.
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                period_d[i] = cfg_period;
            end

            if (restart[i]) begin
                cnt_d[i]   = '0;
                armed_d[i] = 1'b1;
            end else if (pause || !en[i] || (mode[i] && !armed_q[i])) begin
                cnt_d[i] = cnt_q[i];
            end else if (cnt_q[i] >= last_cnt[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                if (mode[i]) begin
                    armed_d[i] = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= CNT_W'(DEFAULT_PERIOD);
                cnt_q[i]    <= '0;
            end
            armed_q <= '1;
            tick_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            armed_q <= armed_d;
            tick_q  <= tick_d;
        end
    end

    assign tick   = tick_q;
    assign active = en & ~{NUM_CH{pause}} & (~mode | armed_q);

endmodule
